// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage program counter: next-PC source,
// halt state and the return-address-stack pointer width helper.
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_REDIRECT,
      SRC_HALT,
      SRC_JR,
      SRC_JUMP,
      SRC_BRANCH,
      SRC_SEQ,
      SRC_HOLD
   } next_src_t;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } halt_state_t;

   // Pointer width for a power-of-two deep stack; never narrower than one bit.
   function automatic int ras_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: newest entry at top_ptr, pushes past full
// overwrite the oldest slot, popping an empty stack is ignored but recorded.
module ras_stack
   import pc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_top,
   output logic             o_valid,
   output logic             o_overflow,
   output logic             o_underflow
);

   localparam int PW = ras_ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    top_ptr;
   logic [PW-1:0]    next_ptr;
   logic [CW-1:0]    count;
   logic             empty;
   logic             replace;

   assign empty    = (count == '0);
   assign next_ptr = top_ptr + PW'(1);
   // Push and pop together on a non-empty stack rewrites the top in place.
   assign replace  = i_push & i_pop & ~empty;

   always_ff @(negedge i_clk) begin
      if (i_reset) begin
         top_ptr     <= '0;
         count       <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_push && !replace) begin
         top_ptr <= next_ptr;
         if (count == FULL) o_overflow <= 1'b1;
         else               count <= count + CW'(1);
      end else if (i_pop && !i_push) begin
         if (empty) begin
            o_underflow <= 1'b1;
         end else begin
            count   <= count - CW'(1);
            top_ptr <= top_ptr - PW'(1);
         end
      end
   end

   always_ff @(negedge i_clk) begin
      if (!i_reset && i_push) begin
         if (replace) mem[top_ptr]  <= i_data;
         else         mem[next_ptr] <= i_data;
      end
   end

   assign o_valid = ~empty;
   assign o_top   = empty ? '0 : mem[top_ptr];

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection, stall and
// debug-step gating, a RUN/HALTED latch and a return-address stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int SIZE_ADDR_PC = 32,
   parameter int INSTR_BYTES  = 4,
   parameter int RAS_DEPTH    = 4,
   parameter logic [SIZE_ADDR_PC-1:0] RESET_VECTOR = '0
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_step,
   input  logic                    i_pc_write,
   input  logic                    i_redirect,
   input  logic [SIZE_ADDR_PC-1:0] i_redirect_addr,
   input  logic                    i_jr,
   input  logic [SIZE_ADDR_PC-1:0] i_jr_addr,
   input  logic                    i_jump,
   input  logic [SIZE_ADDR_PC-1:0] i_jump_addr,
   input  logic                    i_branch_taken,
   input  logic [SIZE_ADDR_PC-1:0] i_branch_addr,
   input  logic                    i_halt,
   input  logic                    i_resume,
   input  logic                    i_ras_push,
   input  logic                    i_ras_pop,
   output logic [SIZE_ADDR_PC-1:0] o_pc,
   output logic [SIZE_ADDR_PC-1:0] o_pc_4,
   output logic [SIZE_ADDR_PC-1:0] o_pc_8,
   output logic                    o_halted,
   output logic [SIZE_ADDR_PC-1:0] o_ras_top,
   output logic                    o_ras_valid,
   output logic                    o_ras_overflow,
   output logic                    o_ras_underflow
);

   localparam logic [SIZE_ADDR_PC-1:0] ALIGN_MASK = ~(SIZE_ADDR_PC'(INSTR_BYTES - 1));

   halt_state_t             state;
   next_src_t               src;
   logic [SIZE_ADDR_PC-1:0] pc_q;
   logic                    adv;

   assign o_pc     = pc_q;
   assign o_pc_4   = pc_q + SIZE_ADDR_PC'(INSTR_BYTES);
   assign o_pc_8   = pc_q + SIZE_ADDR_PC'(2 * INSTR_BYTES);
   assign o_halted = (state == ST_HALTED);
   assign adv      = i_step & i_pc_write & (state == ST_RUN);

   always_comb begin
      src = SRC_HOLD;
      if (i_step) begin
         if (i_redirect)               src = SRC_REDIRECT;
         else if (adv & i_halt)        src = SRC_HALT;
         else if (adv & i_jr)          src = SRC_JR;
         else if (adv & i_jump)        src = SRC_JUMP;
         else if (adv & i_branch_taken) src = SRC_BRANCH;
         else if (adv)                 src = SRC_SEQ;
      end
   end

   always_ff @(negedge i_clk) begin
      if (i_reset) begin
         pc_q  <= RESET_VECTOR;
         state <= ST_RUN;
      end else begin
         case (src)
            SRC_REDIRECT: begin
               pc_q  <= i_redirect_addr & ALIGN_MASK;
               state <= ST_RUN;
            end
            SRC_HALT:   state <= ST_HALTED;
            SRC_JR:     pc_q  <= i_jr_addr & ALIGN_MASK;
            SRC_JUMP:   pc_q  <= i_jump_addr & ALIGN_MASK;
            SRC_BRANCH: pc_q  <= i_branch_addr & ALIGN_MASK;
            SRC_SEQ:    pc_q  <= o_pc_4;
            default: begin
               // Resuming leaves the PC where the halt froze it.
               if (state == ST_HALTED && i_step && i_resume) state <= ST_RUN;
            end
         endcase
      end
   end

   ras_stack #(
      .WIDTH (SIZE_ADDR_PC),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (adv & ~i_redirect & i_ras_push),
      .i_pop       (adv & ~i_redirect & i_ras_pop),
      .i_data      (o_pc_8),
      .o_top       (o_ras_top),
      .o_valid     (o_ras_valid),
      .o_overflow  (o_ras_overflow),
      .o_underflow (o_ras_underflow)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each cycle's expected outputs are queued as the
// stimulus is driven and compared just after the falling edge that consumes it.
module tb_pc_unit;

   localparam int W  = 32;
   localparam int EW = W + 1 + W + 3;

   logic         clk = 1'b0;
   logic         reset;
   logic         step, pc_write, redirect, jr, jump, branch_taken, halt, resume;
   logic         ras_push, ras_pop;
   logic [W-1:0] redirect_addr, jr_addr, jump_addr, branch_addr;
   logic [W-1:0] pc, pc_4, pc_8, ras_top;
   logic         halted, ras_valid, ras_overflow, ras_underflow;

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   always #5 clk = ~clk;

   pc_unit #(
      .SIZE_ADDR_PC (W),
      .INSTR_BYTES  (4),
      .RAS_DEPTH    (4),
      .RESET_VECTOR (32'h100)
   ) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_step          (step),
      .i_pc_write      (pc_write),
      .i_redirect      (redirect),
      .i_redirect_addr (redirect_addr),
      .i_jr            (jr),
      .i_jr_addr       (jr_addr),
      .i_jump          (jump),
      .i_jump_addr     (jump_addr),
      .i_branch_taken  (branch_taken),
      .i_branch_addr   (branch_addr),
      .i_halt          (halt),
      .i_resume        (resume),
      .i_ras_push      (ras_push),
      .i_ras_pop       (ras_pop),
      .o_pc            (pc),
      .o_pc_4          (pc_4),
      .o_pc_8          (pc_8),
      .o_halted        (halted),
      .o_ras_top       (ras_top),
      .o_ras_valid     (ras_valid),
      .o_ras_overflow  (ras_overflow),
      .o_ras_underflow (ras_underflow)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
   endtask

   task automatic idle();
      reset = 1'b0; step = 1'b1; pc_write = 1'b1;
      redirect = 1'b0; jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      halt = 1'b0; resume = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
      redirect_addr = '0; jr_addr = '0; jump_addr = '0; branch_addr = '0;
   endtask

   // flags = {ras_valid, ras_overflow, ras_underflow}
   task automatic cyc(input logic [W-1:0] e_pc, input logic e_h,
                      input logic [W-1:0] e_top, input logic [2:0] e_f);
      logic [EW-1:0] e;
      exp_q.push_back({e_pc, e_h, e_top, e_f});
      @(negedge clk);
      #1;
      e = exp_q.pop_front();
      check("pc",     pc,   e[EW-1 -: W]);
      check("pc_4",   pc_4, e[EW-1 -: W] + 32'd4);
      check("pc_8",   pc_8, e[EW-1 -: W] + 32'd8);
      check("halted", {31'd0, halted}, {31'd0, e[W+3]});
      check("ras_top", ras_top, e[W+2 -: W]);
      check("ras_flags", {29'd0, ras_valid, ras_overflow, ras_underflow}, {29'd0, e[2:0]});
      idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      // Reset ignores a deasserted step.
      reset = 1'b1; step = 1'b0;           cyc(32'h100, 0, 0, 3'b000);
      cyc(32'h104, 0, 0, 3'b000);
      cyc(32'h108, 0, 0, 3'b000);
      cyc(32'h10C, 0, 0, 3'b000);
      step = 1'b0; jump = 1'b1; jump_addr = 32'h500; cyc(32'h10C, 0, 0, 3'b000);
      redirect = 1'b1; redirect_addr = 32'h40;      cyc(32'h40, 0, 0, 3'b000);
      pc_write = 1'b0;                              cyc(32'h40, 0, 0, 3'b000);
      pc_write = 1'b0; jump = 1'b1; jump_addr = 32'h300; cyc(32'h40, 0, 0, 3'b000);
      branch_taken = 1'b1; branch_addr = 32'h80;
      jump = 1'b1; jump_addr = 32'h200;             cyc(32'h200, 0, 0, 3'b000);
      jr = 1'b1; jr_addr = 32'h103; jump = 1'b1; jump_addr = 32'h400; cyc(32'h100, 0, 0, 3'b000);
      branch_taken = 1'b1; branch_addr = 32'h8B;    cyc(32'h88, 0, 0, 3'b000);
      // Halt wins over a simultaneous jump and freezes the PC.
      redirect = 1'b1; redirect_addr = 32'h20;      cyc(32'h20, 0, 0, 3'b000);
      halt = 1'b1; jump = 1'b1; jump_addr = 32'h300; cyc(32'h20, 1, 0, 3'b000);
      jump = 1'b1; jump_addr = 32'h300;             cyc(32'h20, 1, 0, 3'b000);
      resume = 1'b1;                                cyc(32'h20, 0, 0, 3'b000);
      cyc(32'h24, 0, 0, 3'b000);
      halt = 1'b1;                                  cyc(32'h24, 1, 0, 3'b000);
      redirect = 1'b1; redirect_addr = 32'h180; pc_write = 1'b0; cyc(32'h180, 0, 0, 3'b000);
      // Wrap at the top of the address space.
      redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; cyc(32'hFFFF_FFFC, 0, 0, 3'b000);
      cyc(32'h0, 0, 0, 3'b000);
      // A redirect never touches the stack.
      redirect = 1'b1; redirect_addr = 32'h0; ras_push = 1'b1; cyc(32'h0, 0, 0, 3'b000);
      ras_push = 1'b1; jump = 1'b1; jump_addr = 32'h10; cyc(32'h10, 0, 32'h08, 3'b100);
      ras_push = 1'b1; jump = 1'b1; jump_addr = 32'h20; cyc(32'h20, 0, 32'h18, 3'b100);
      ras_push = 1'b1; jump = 1'b1; jump_addr = 32'h30; cyc(32'h30, 0, 32'h28, 3'b100);
      ras_push = 1'b1; jump = 1'b1; jump_addr = 32'h40; cyc(32'h40, 0, 32'h38, 3'b100);
      ras_push = 1'b1; jump = 1'b1; jump_addr = 32'h50; cyc(32'h50, 0, 32'h48, 3'b110);
      ras_pop = 1'b1;                               cyc(32'h54, 0, 32'h38, 3'b110);
      ras_pop = 1'b1;                               cyc(32'h58, 0, 32'h28, 3'b110);
      ras_pop = 1'b1;                               cyc(32'h5C, 0, 32'h18, 3'b110);
      ras_pop = 1'b1;                               cyc(32'h60, 0, 32'h0, 3'b010);
      ras_pop = 1'b1;                               cyc(32'h64, 0, 32'h0, 3'b011);
      pc_write = 1'b0; ras_push = 1'b1;             cyc(32'h64, 0, 32'h0, 3'b011);
      reset = 1'b1;                                 cyc(32'h100, 0, 0, 3'b000);
      // Push+pop with two entries replaces the top only.
      redirect = 1'b1; redirect_addr = 32'h50;      cyc(32'h50, 0, 0, 3'b000);
      ras_push = 1'b1; jump = 1'b1; jump_addr = 32'h58; cyc(32'h58, 0, 32'h58, 3'b100);
      ras_push = 1'b1; jump = 1'b1; jump_addr = 32'h60; cyc(32'h60, 0, 32'h60, 3'b100);
      ras_push = 1'b1; ras_pop = 1'b1;              cyc(32'h64, 0, 32'h68, 3'b100);
      ras_pop = 1'b1;                               cyc(32'h68, 0, 32'h58, 3'b100);
      ras_pop = 1'b1;                               cyc(32'h6C, 0, 32'h0, 3'b000);
      // Push+pop on an empty stack behaves as a push.
      ras_push = 1'b1; ras_pop = 1'b1;              cyc(32'h70, 0, 32'h74, 3'b100);
      // Reset mid-halt overrides a simultaneous redirect.
      halt = 1'b1;                                  cyc(32'h70, 1, 32'h74, 3'b100);
      reset = 1'b1; redirect = 1'b1; redirect_addr = 32'h300; cyc(32'h100, 0, 0, 3'b000);
      step = 1'b0; redirect = 1'b1; redirect_addr = 32'h200; cyc(32'h100, 0, 0, 3'b000);
      check("sb_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS pipeline fetch stage. It holds the PC and selects the next PC by fixed priority among redirect, jump-register, jump, branch and sequential sources. It gates every update with the debug single-step enable and the hazard-unit write enable, and latches a halt state. An internal return-address stack (RAS) records JAL link addresses so IF can predict `JR $ra`.

## Interface
- SIZE_ADDR_PC, 32, PC/address width in bits (≥ 8)
- INSTR_BYTES, 4, sequential increment; power of two
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2
- RESET_VECTOR, 0, PC value loaded on reset
- i_clk  in  1  clock; all state updates on falling edge
- i_reset  in  1  reset i_reset, synchronous, active-high
- i_step  in  1  debug step enable; 0 freezes all state except reset
- i_pc_write  in  1  hazard unit; 0 = stall (bubble)
- i_redirect  in  1  exception/debug redirect request
- i_redirect_addr  in  SIZE_ADDR_PC  redirect target
- i_jr  in  1  jump-register taken
- i_jr_addr  in  SIZE_ADDR_PC  JR/JALR target
- i_jump  in  1  J/JAL taken
- i_jump_addr  in  SIZE_ADDR_PC  J/JAL target
- i_branch_taken  in  1  conditional branch resolved taken
- i_branch_addr  in  SIZE_ADDR_PC  branch target
- i_halt  in  1  HALT instruction decoded
- i_resume  in  1  leave halted state
- i_ras_push  in  1  JAL/JALR: push link address
- i_ras_pop  in  1  JR $ra: pop
- o_pc  out  SIZE_ADDR_PC  current PC
- o_pc_4  out  SIZE_ADDR_PC  o_pc + INSTR_BYTES
- o_pc_8  out  SIZE_ADDR_PC  o_pc + 2·INSTR_BYTES (JAL link)
- o_halted  out  1  halt state
- o_ras_top  out  SIZE_ADDR_PC  top RAS entry; 0 when empty
- o_ras_valid  out  1  RAS non-empty
- o_ras_overflow  out  1  sticky: push while full
- o_ras_underflow  out  1  sticky: pop while empty

## Operation
- adv = i_step & i_pc_write & ~o_halted.
- Next-PC priority, evaluated only when i_step = 1:
  1. i_redirect: PC ← i_redirect_addr. Ignores i_pc_write and halted, and clears o_halted.
  2. adv & i_halt: PC unchanged; o_halted ← 1.
  3. adv & i_jr: PC ← i_jr_addr.
  4. adv & i_jump: PC ← i_jump_addr.
  5. adv & i_branch_taken: PC ← i_branch_addr.
  6. adv: PC ← o_pc_4.
  7. Otherwise PC is held.
- Halt state, two states RUN and HALTED:
  - RUN→HALTED on rule 2.
  - HALTED→RUN on i_step & i_resume, with PC unchanged, or on a redirect.
- Targets are loaded with their log2(INSTR_BYTES) LSBs forced to 0.
- o_pc_4 and o_pc_8 are combinational, with modulo-2^SIZE_ADDR_PC wrap (0xFFFFFFFC + 4 = 0).
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH). It acts only when adv is 1 and no redirect is present:
  - push only: entry ← o_pc_8, count + 1. When full, the oldest entry is overwritten, count stays RAS_DEPTH, and o_ras_overflow ← 1.
  - pop only: count − 1. When empty there is no change and o_ras_underflow ← 1.
  - push & pop: top entry is replaced by o_pc_8 and count is unchanged. When empty this acts as a plain push.
- Redirect does not modify the RAS.

## Timing
- Reset, on the falling edge with i_reset = 1, regardless of i_step:
  - o_pc = RESET_VECTOR, o_halted = 0.
  - RAS count = 0, o_ras_valid = 0, o_ras_top = 0.
  - Both sticky flags = 0. RAS contents are don't-care.
- PC, halt and RAS update on the falling edge after the inputs are sampled. Outputs are valid during the following rising-edge half of the cycle, for IF memory and IF/ID latches.
- Latency is one falling edge from request to new o_pc. There is no handshake; the inputs are level-sampled.
- A reset asserted mid-halt or mid-stall takes effect on that edge; a simultaneous redirect is ignored.
- A simultaneous i_halt and i_jump with adv = 1 halts; the jump is discarded.

## Structure
- Package pc_pkg holds:
  - next-PC source encoding (SRC_REDIRECT, SRC_HALT, SRC_JR, SRC_JUMP, SRC_BRANCH, SRC_SEQ, SRC_HOLD)
  - halt-state encoding
  - a clog2-based helper for the RAS pointer width
- Sub-module ras_stack holds the circular buffer, count, top pointer and sticky flags, parametrised by width and depth.
- pc_unit contains the priority selector, PC register and halt FSM.

## Test plan
- Reset with RESET_VECTOR = 0x100, then 3 edges with i_step = i_pc_write = 1 → o_pc goes 0x100, 0x104, 0x108, 0x10C; o_pc_8 = 0x114 at the end.
- At PC 0x40, i_pc_write = 0 for 2 edges, then i_branch_taken = 1 with i_jump = 1, i_jump_addr = 0x200, i_branch_addr = 0x80 → o_pc holds at 0x40, then becomes 0x200. Also: i_step = 0 freezes the PC.
- i_halt at PC 0x20 → o_halted = 1 and PC stays 0x20 despite jumps; i_resume → next edge gives 0x20, then 0x24. Redirect to 0x180 while halted → o_pc = 0x180, o_halted = 0.
- RAS_DEPTH = 4: JAL pushes at PCs 0x0, 0x10, 0x20, 0x30, 0x40 → o_ras_overflow = 1 and o_ras_top = 0x48. Four pops → top walks 0x38, 0x28, 0x18, then o_ras_valid = 0. A fifth pop → o_ras_underflow = 1.
- Simultaneous push + pop at PC 0x60 with count 2 → count stays 2, top = 0x68.
- At PC 0xFFFFFFFC with SIZE_ADDR_PC = 32, advance → o_pc = 0x0. i_jr_addr = 0x103 → o_pc = 0x100.
